// File: rtl/serial_adder_pkg.sv
// Shared types and constants for the bit-serial adder.
package serial_adder_pkg;
  localparam int DEFAULT_WIDTH = 8;

  typedef enum logic [1:0] {IDLE, SHIFT, DONE} state_t;
endpackage

// File: rtl/serial_adder_if.sv
// Operand/result bundle between a requester (master) and the serial adder (slave).
interface serial_adder_if
  import serial_adder_pkg::*;
#(
  parameter int WIDTH = DEFAULT_WIDTH
);
  logic             start;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             cin;
  logic             busy;
  logic             done;
  logic [WIDTH-1:0] sum;
  logic             cout;

  modport master (output start, a, b, cin, input busy, done, sum, cout);
  modport slave  (input start, a, b, cin, output busy, done, sum, cout);
endinterface

// File: rtl/fulladder.sv
// Single-bit full adder.
module fulladder (
  input  logic x,
  input  logic y,
  input  logic z,
  output logic s,
  output logic c
);
  assign s = x ^ y ^ z;
  assign c = (x & y) | (z & (x ^ y));
endmodule

// File: rtl/serial_adder.sv
// Bit-serial adder: one full-adder step per cycle, LSB first, result published
// on entry to DONE together with a one-cycle done pulse.
module serial_adder
  import serial_adder_pkg::*;
#(
  parameter int WIDTH = DEFAULT_WIDTH
) (
  input  logic          clk,
  input  logic          rst_n,
  serial_adder_if.slave bus
);
  localparam int CW = $clog2(WIDTH + 1);

  state_t           state, state_nxt;
  logic [WIDTH-1:0] opa, opb, psum, psum_nxt;
  logic             carry;
  logic [CW-1:0]    cnt;
  logic             fa_s, fa_c;
  logic             last;

  fulladder u_fa (.x(opa[0]), .y(opb[0]), .z(carry), .s(fa_s), .c(fa_c));

  assign last = (cnt == CW'(WIDTH - 1));

  always_comb begin
    psum_nxt            = psum >> 1;
    psum_nxt[WIDTH-1]   = fa_s;
  end

  always_comb begin
    state_nxt = state;
    unique case (state)
      IDLE:    if (bus.start) state_nxt = SHIFT;
      SHIFT:   if (last)      state_nxt = DONE;
      DONE:                   state_nxt = IDLE;
      default:                state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  // busy/done are registered copies of the next state so outputs come straight from flops
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      opa      <= '0;
      opb      <= '0;
      psum     <= '0;
      carry    <= 1'b0;
      cnt      <= '0;
      bus.busy <= 1'b0;
      bus.done <= 1'b0;
      bus.sum  <= '0;
      bus.cout <= 1'b0;
    end else begin
      bus.busy <= (state_nxt == SHIFT);
      bus.done <= (state_nxt == DONE);
      case (state)
        IDLE: if (bus.start) begin
          opa   <= bus.a;
          opb   <= bus.b;
          carry <= bus.cin;
          cnt   <= '0;
        end
        SHIFT: begin
          psum  <= psum_nxt;
          carry <= fa_c;
          opa   <= opa >> 1;
          opb   <= opb >> 1;
          cnt   <= cnt + 1'b1;
          if (last) begin
            bus.sum  <= psum_nxt;
            bus.cout <= fa_c;
          end
        end
        default: ;
      endcase
    end
  end
endmodule

// File: tb/tb_serial_adder.sv
// Scoreboard bench for serial_adder at WIDTH=8 and WIDTH=1.
module tb_serial_adder;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  serial_adder_if #(.WIDTH(8)) bus8 ();
  serial_adder_if #(.WIDTH(1)) bus1 ();

  serial_adder #(.WIDTH(8)) dut8 (.clk(clk), .rst_n(rst_n), .bus(bus8));
  serial_adder #(.WIDTH(1)) dut1 (.clk(clk), .rst_n(rst_n), .bus(bus1));

  int tests = 0;
  int fails = 0;
  logic [8:0] q8[$];
  logic [1:0] q1[$];
  logic [8:0] last8 = '0;
  logic [1:0] last1 = '0;

  // full-adder truth table indexed by {a,b,cin}, value {cout,sum}
  logic [1:0] ft [8] = '{2'b00, 2'b01, 2'b01, 2'b10, 2'b01, 2'b10, 2'b10, 2'b11};

  task automatic check(string name, logic [31:0] act, logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  always @(negedge clk) begin
    if (!rst_n) last8 = '0;
    else if (bus8.done) begin
      if (q8.size() == 0) check("w8 unexpected done", 1, 0);
      else begin
        last8 = q8.pop_front();
        check("w8 result", {bus8.cout, bus8.sum}, last8);
      end
    end else check("w8 hold", {bus8.cout, bus8.sum}, last8);
  end

  always @(negedge clk) begin
    if (!rst_n) last1 = '0;
    else if (bus1.done) begin
      if (q1.size() == 0) check("w1 unexpected done", 1, 0);
      else begin
        last1 = q1.pop_front();
        check("w1 result", {bus1.cout, bus1.sum}, last1);
      end
    end else check("w1 hold", {bus1.cout, bus1.sum}, last1);
  end

  // Issue one op, scramble inputs after acceptance, measure latency/busy length.
  // inj>0 re-asserts start with 0xFF operands during that SHIFT cycle.
  task automatic run_op(bit w1, logic [7:0] a, logic [7:0] b, logic ci,
                        logic [8:0] exp, int inj);
    int lat = 0;
    int bcnt = 0;
    bit got = 0;
    int w = w1 ? 1 : 8;
    @(posedge clk); #1;
    if (w1) begin
      bus1.start = 1'b1; bus1.a = a[0]; bus1.b = b[0]; bus1.cin = ci;
      q1.push_back(exp[1:0]);
    end else begin
      bus8.start = 1'b1; bus8.a = a; bus8.b = b; bus8.cin = ci;
      q8.push_back(exp);
    end
    @(posedge clk); #1;
    bus1.start = 1'b0; bus1.a = ~a[0]; bus1.b = ~b[0]; bus1.cin = ~ci;
    bus8.start = 1'b0; bus8.a = ~a;    bus8.b = 8'($urandom); bus8.cin = ~ci;
    for (int i = 0; i < 40 && !got; i++) begin
      @(negedge clk);
      lat++;
      if (lat == inj) begin
        bus8.start = 1'b1; bus8.a = 8'hFF; bus8.b = 8'hFF;
      end else bus8.start = 1'b0;
      if (w1 ? bus1.busy : bus8.busy) bcnt++;
      if (w1 ? bus1.done : bus8.done) got = 1;
    end
    bus8.start = 1'b0;
    check(w1 ? "w1 latency" : "w8 latency", got ? lat : -1, w + 1);
    check(w1 ? "w1 busy cycles" : "w8 busy cycles", bcnt, w);
  endtask

  initial begin
    bus8.start = 1'b1; bus8.a = 8'h12; bus8.b = 8'h34; bus8.cin = 1'b0;
    bus1.start = 1'b1; bus1.a = 1'b1;  bus1.b = 1'b1;  bus1.cin = 1'b1;
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1; bus8.start = 1'b0; bus1.start = 1'b0;
    @(negedge clk);
    check("reset busy", bus8.busy, 0);
    check("reset done", bus8.done, 0);
    check("reset result", {bus8.cout, bus8.sum}, 0);
    check("reset w1 busy", bus1.busy, 0);

    run_op(0, 8'h00, 8'h00, 1'b0, 9'h000, 0);
    run_op(0, 8'hFF, 8'h01, 1'b0, 9'h100, 0);
    run_op(0, 8'hA5, 8'h5A, 1'b1, 9'h100, 0);
    run_op(0, 8'h12, 8'h34, 1'b0, 9'h046, 3);
    repeat (15) @(negedge clk);

    // abort mid-SHIFT: no done, result reads zero
    @(posedge clk); #1;
    bus8.start = 1'b1; bus8.a = 8'h77; bus8.b = 8'h11; bus8.cin = 1'b0;
    q8.push_back(9'h088);
    @(posedge clk); #1 bus8.start = 1'b0;
    repeat (4) @(negedge clk);
    check("busy before abort", bus8.busy, 1);
    @(posedge clk); #1 rst_n = 1'b0;
    q8.delete();
    @(posedge clk); #1 rst_n = 1'b1;
    @(negedge clk);
    check("abort busy", bus8.busy, 0);
    check("abort done", bus8.done, 0);
    check("abort result", {bus8.cout, bus8.sum}, 0);
    repeat (12) @(negedge clk);

    for (int i = 0; i < 8; i++)
      run_op(1, {7'd0, i[2]}, {7'd0, i[1]}, i[0], {7'd0, ft[i]}, 0);

    for (int n = 0; n < 1000; n++) begin
      logic [7:0] ra, rb;
      logic       rc;
      ra = 8'($urandom); rb = 8'($urandom); rc = 1'($urandom);
      run_op(0, ra, rb, rc, 9'(ra) + 9'(rb) + 9'(rc), 0);
    end

    repeat (5) @(negedge clk);
    check("scoreboard drained", q8.size() + q1.size(), 0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule

// File: doc/serial_adder.md
SERIAL_ADDER -- requirements
Module: serial_adder

Interface
REQ-001 Parameter: WIDTH, default 8, operand/result width in bits (legal range 1..32).
REQ-002 Clocking: one clock; reset is synchronous and active-low.
REQ-003 clk  input  1  rising-edge clock for all state.
REQ-004 rst_n  input  1  synchronous active-low reset.
REQ-005 start  input  1  request to begin one addition; sampled only in IDLE.
REQ-006 a  input  WIDTH  operand A; captured on accepted start.
REQ-007 b  input  WIDTH  operand B; captured on accepted start.
REQ-008 cin  input  1  carry-in; captured on accepted start.
REQ-009 busy  output  1  high while the adder is in SHIFT.
REQ-010 done  output  1  one-cycle pulse: sum/cout freshly valid.
REQ-011 sum  output  WIDTH  registered result, LSB first computed.
REQ-012 cout  output  1  registered carry-out of the MSB.

Function
REQ-013 The FSM SHALL have exactly three states: IDLE, SHIFT, DONE.
REQ-014 IDLE + start=1 at edge k: load a, b into operand shift registers, cin into carry flop, clear bit counter, go to SHIFT.
REQ-015 IDLE + start=0: remain in IDLE; all registers hold.
REQ-016 SHIFT, each cycle: one full-adder evaluation on operand LSBs plus carry flop; sum bit shifted into the MSB of the partial-sum register; carry flop takes the adder carry; operands shift right by one; counter increments.
REQ-017 SHIFT SHALL last exactly WIDTH cycles (edges k+1..k+WIDTH), then go to DONE.
REQ-018 Entry to DONE: sum and cout output registers updated from partial-sum register and carry flop.
REQ-019 DONE: done=1 for exactly one cycle (cycle after edge k+WIDTH), then unconditionally go to IDLE.
REQ-020 Latency: done high WIDTH+1 cycles after the edge that accepted start.
REQ-021 busy=1 in SHIFT only; busy=0 in IDLE and DONE.
REQ-022 start in SHIFT or DONE SHALL be ignored (no queueing, no restart, operands unchanged).
REQ-023 a, b, cin changes after acceptance SHALL not affect the result in progress.
REQ-024 sum and cout SHALL hold their last value from DONE until the next DONE; never show partial results.
REQ-025 Result SHALL equal {cout,sum} = a + b + cin, modulo 2^(WIDTH+1), no overflow flag.
REQ-026 Counter width: clog2(WIDTH+1) bits; terminal compare at WIDTH-1 in SHIFT; no wrap beyond.
REQ-027 WIDTH=1: SHIFT lasts one cycle; behaviour otherwise identical.

Reset
REQ-028 rst_n=0 at a clock edge SHALL force state=IDLE, busy=0, done=0, sum=0, cout=0, counter=0, carry flop=0, shift registers=0.
REQ-029 Reset mid-SHIFT or in DONE SHALL abort the operation; no done pulse; sum/cout read 0.
REQ-030 start coincident with rst_n=0 SHALL be ignored; first acceptable start is the edge after rst_n returns high.

Structure
REQ-031 Shared package serial_adder_pkg SHALL hold the state enumeration typedef (IDLE, SHIFT, DONE) and the default WIDTH constant.
REQ-032 The single-bit addition SHALL be an instance of the team's existing full-adder sub-module fulladder (ports x, y, z, s, c); no other sub-modules.
REQ-033 All outputs SHALL be driven directly from flops.

Verification
REQ-034 WIDTH=8, a=0x00 b=0x00 cin=0, start one cycle -> busy 8 cycles, done pulse at cycle 9, sum=0x00 cout=0.
REQ-035 WIDTH=8, a=0xFF b=0x01 cin=0 -> sum=0x00 cout=1; a=0xA5 b=0x5A cin=1 -> sum=0x00 cout=1.
REQ-036 WIDTH=8, start a=0x12 b=0x34, then start again with a=0xFF b=0xFF at SHIFT cycle 3 -> single done, sum=0x46 cout=0.
REQ-037 WIDTH=8, rst_n=0 at SHIFT cycle 4 -> next cycle IDLE, busy=0, sum=0x00, no done pulse.
REQ-038 WIDTH=1, all 8 combinations of a,b,cin -> {cout,sum} matches full-adder truth table, done 2 cycles after each start.
REQ-039 WIDTH=8, 1000 random back-to-back operations (start reasserted first IDLE cycle after done) -> every result equals a+b+cin, result stable between done pulses.
